blackjack_top: RTL and testbench
================================

BLACKJACK_TOP -- requirements
Module: blackjack_top

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk in 1 (rising-edge clock); reset in 1 (synchronous, active-high).
REQ-002 SHALL have parameter DECK, default 16x6-bit {7,10,10,8,4,10,2,9,5,3,6,11,10,10,8,2}, meaning the card draw order, first entry first.
REQ-003 SHALL have parameter INIT_COIN, default 10, meaning coins after reset.
REQ-004 SHALL have inputs next, hit, stand, double, split (1 bit each), meaning level buttons acted on at their rising edge.
REQ-005 SHALL have inputs bet_8, bet_4, bet_2, bet_1 (1 bit each), meaning bet = {bet_8,bet_4,bet_2,bet_1}, 0..15.
REQ-006 SHALL have outputs player_current_score and player_new_card, out 6, meaning main hand score and last card drawn to it.
REQ-007 SHALL have outputs player_current_score_split and player_new_card_split, out 6, meaning the same for split hand 2.
REQ-008 SHALL have output dealer_current_score, out 6, meaning dealer hand score.
REQ-009 SHALL have output current_coin, out 5, meaning coin balance.
REQ-010 SHALL have outputs can_split, Win, Lose, Draw, out 1, meaning split allowed and the round-result flags.

Function
REQ-011 Each button SHALL be edge-detected with a registered copy: action in the cycle after a 0->1 transition, exactly once per press.
REQ-012 FSM states SHALL be BET, DEAL_DEALER, DEAL_PLAYER, PLAYER, HAND1, HAND2, WAIT_DEALER, DEALER, RESULT.
REQ-013 BET: next with 1 <= bet <= current_coin SHALL latch the bet and go to DEAL_DEALER; otherwise next SHALL be ignored.
REQ-014 DEAL_DEALER SHALL draw two dealer cards on consecutive cycles; then next SHALL go to DEAL_PLAYER.
REQ-015 DEAL_PLAYER SHALL draw two player cards on consecutive cycles, then enter PLAYER.
REQ-016 Drawing SHALL take the card from a deck pointer; the pointer SHALL advance by 1 per draw and wrap 15->0.
REQ-017 Card values SHALL be 2..11, with 11 = ace.
REQ-018 Score SHALL be the sum of cards; while score > 21 and a counted-11 ace remains, 10 SHALL be subtracted (soft-ace count per hand).
REQ-019 can_split SHALL be 1 only in PLAYER with exactly two equal-valued cards and 2*bet <= current_coin.
REQ-020 PLAYER hit SHALL draw one card; a score > 21 SHALL go directly to RESULT.
REQ-021 PLAYER stand SHALL go to DEALER.
REQ-022 PLAYER double (two cards only, 2*bet <= coin) SHALL double the bet, draw one card and go to WAIT_DEALER, or to RESULT on bust.
REQ-023 A two-card 21 (blackjack) SHALL go to WAIT_DEALER automatically, with no further hit/double/split accepted.
REQ-024 WAIT_DEALER: next SHALL go to DEALER.
REQ-025 PLAYER split (can_split=1) SHALL move card 2 to hand 2, draw one card to hand 1 and enter HAND1.
REQ-026 HAND1: hit SHALL draw; on bust, next SHALL enter HAND2; stand SHALL enter HAND2.
REQ-027 Entering HAND2 SHALL draw one card to hand 2; in HAND2, hit SHALL draw and stand or bust SHALL go to DEALER.
REQ-028 DEALER SHALL draw one card per cycle while dealer score < 17, then stop; next SHALL go to RESULT.
REQ-029 RESULT per hand: bust -> Lose; else dealer bust -> Win; player blackjack vs dealer non-blackjack -> Win; else compare (greater Win, equal Draw, less Lose).
REQ-030 Win/Lose/Draw SHALL report the main/hand-1 result, be one-hot in RESULT and 0 elsewhere.
REQ-031 Coins SHALL settle once on RESULT entry: Win +bet (blackjack +bet+bet/2, floored); Lose -bet; Draw 0; each split hand settled with its own bet.
REQ-032 Coin arithmetic SHALL saturate at 31 and 0.
REQ-033 RESULT: next SHALL clear hands and scores and return to BET; the deck pointer SHALL be kept.
REQ-034 Simultaneous button edges SHALL be prioritised next > stand > double > split > hit; edges not valid in the current state SHALL be ignored.

Reset
REQ-035 reset SHALL, at any state including mid-round, set state BET, coin = INIT_COIN, deck pointer 0, bet 0, all scores/cards/flags/can_split 0, and the edge registers 0.

Structure
REQ-036 A shared package SHALL hold the state enum, the DECK default, the constants 17/21/11, and the card width 6.
REQ-037 A single sub-module card_generation (deck ROM + pointer, draw strobe in, card out) SHALL exist; all else SHALL be in blackjack_top.

Verification
REQ-038 Default deck, bet 3, next, next: dealer 17; player 10,8 = 18; hit -> new card 4, score 22, Lose=1 after next; coin 10->7.
REQ-039 Deck {7,10,10,8,2,...}, bet 3, double -> card 2, score 20; next, next -> dealer 17, Win=1; coin 10->16.
REQ-040 Deck {7,10,10,11,...}, bet 3, next, next: score 21 blackjack, Win=1, coin 10->14.
REQ-041 Deck {7,10,10,10,8,4,8,2,...}, bet 3: can_split=1; split -> hand1 18; hit -> 22; next -> hand2 18; hit -> 20; stand; next -> Lose=1, coin 10->10.
REQ-042 Reset asserted in PLAYER -> next cycle coin 10, all scores 0, BET; bet 0 + next -> stays BET.

Source files
------------

// File: rtl/blackjack_pkg.sv
// Shared types, constants and hand arithmetic for the blackjack table.
// A hand is tracked as its running score plus the number of aces still counted as 11.
package blackjack_pkg;

   localparam int CARD_W   = 6;
   localparam int DECK_LEN = 16;

   localparam logic [CARD_W-1:0] DEALER_STAND = 6'd17;
   localparam logic [CARD_W-1:0] BLACKJACK    = 6'd21;
   localparam logic [CARD_W-1:0] ACE          = 6'd11;

   localparam logic [DECK_LEN*CARD_W-1:0] DEFAULT_DECK = {
      6'd7, 6'd10, 6'd10, 6'd8, 6'd4, 6'd10, 6'd2, 6'd9,
      6'd5, 6'd3,  6'd6,  6'd11, 6'd10, 6'd10, 6'd8, 6'd2
   };

   typedef enum logic [3:0] {
      BET, DEAL_DEALER, DEAL_PLAYER, PLAYER, HAND1, HAND2, WAIT_DEALER, DEALER, RESULT
   } state_t;

   typedef enum logic [1:0] {RES_LOSE, RES_WIN, RES_DRAW} result_t;

   typedef struct packed {
      logic [3:0]        aces;
      logic [CARD_W-1:0] score;
   } hand_t;

   // Two passes cover adding an ace onto a soft 21.
   function automatic hand_t add_card(input hand_t h, input logic [CARD_W-1:0] card);
      hand_t r;
      r.score = h.score + card;
      r.aces  = h.aces + {3'b000, card == ACE};
      for (int i = 0; i < 2; i++) begin
         if (r.score > BLACKJACK && r.aces != 4'd0) begin
            r.score = r.score - 6'd10;
            r.aces  = r.aces - 4'd1;
         end
      end
      return r;
   endfunction

   function automatic result_t hand_result(input logic [CARD_W-1:0] p, input logic p_bj,
                                           input logic [CARD_W-1:0] d, input logic d_bj);
      if (p > BLACKJACK) return RES_LOSE;
      if (d > BLACKJACK) return RES_WIN;
      if (p_bj && !d_bj) return RES_WIN;
      if (p > d)         return RES_WIN;
      if (p == d)        return RES_DRAW;
      return RES_LOSE;
   endfunction

endpackage

// File: rtl/blackjack_card_generation.sv
// Deck ROM with a wrapping draw pointer; the card under the pointer is always presented
// and the pointer advances on each draw strobe.
module card_generation
   import blackjack_pkg::*;
#(
   parameter logic [DECK_LEN*CARD_W-1:0] DECK = DEFAULT_DECK
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              draw,
   output logic [CARD_W-1:0] card
);

   logic [CARD_W-1:0] rom [DECK_LEN];
   logic [3:0]        ptr_reg;

   // First listed entry sits in the most significant slice.
   generate
      for (genvar gi = 0; gi < DECK_LEN; gi++) begin : g_rom
         assign rom[gi] = DECK[(DECK_LEN-1-gi)*CARD_W +: CARD_W];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_reg <= 4'd0;
      end else if (draw) begin
         ptr_reg <= ptr_reg + 4'd1;
      end
   end

   assign card = rom[ptr_reg];

endmodule

// File: rtl/blackjack_top.sv
// Blackjack round controller: betting, dealing, player actions incl. double and split,
// dealer play and coin settlement.
module blackjack_top
   import blackjack_pkg::*;
#(
   parameter logic [DECK_LEN*CARD_W-1:0] DECK      = DEFAULT_DECK,
   parameter int                         INIT_COIN = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              next,
   input  logic              hit,
   input  logic              stand,
   input  logic              double,
   input  logic              split,
   input  logic              bet_8,
   input  logic              bet_4,
   input  logic              bet_2,
   input  logic              bet_1,
   output logic [CARD_W-1:0] player_current_score,
   output logic [CARD_W-1:0] player_new_card,
   output logic [CARD_W-1:0] player_current_score_split,
   output logic [CARD_W-1:0] player_new_card_split,
   output logic [CARD_W-1:0] dealer_current_score,
   output logic [4:0]        current_coin,
   output logic              can_split,
   output logic              Win,
   output logic              Lose,
   output logic              Draw
);

   state_t state_reg, state_next;

   logic [4:0] btn, btn_reg, btn_edge;
   logic       next_e, stand_e, double_e, split_e, hit_e;

   logic [4:0]        bet_reg, bet_next, coin_reg, coin_next, coin_settled;
   hand_t             p_hand_reg, p_hand_next, s_hand_reg, s_hand_next, d_hand_reg, d_hand_next;
   logic [CARD_W-1:0] p_card_reg, p_card_next, s_card_reg, s_card_next, card1_reg, card1_next;
   logic [3:0]        p_cnt_reg, p_cnt_next, d_cnt_reg, d_cnt_next;
   logic [1:0]        deal_cnt_reg, deal_cnt_next;
   logic              split_reg, split_next, h1_bust_reg, h1_bust_next, settled_reg, settled_next;

   logic              draw;
   logic [CARD_W-1:0] card;
   hand_t             p_add, s_add, d_add, split_base, h1_split;
   logic [4:0]        bet_in;
   logic [5:0]        bet_dbl;
   logic              double_ok, player_bj, dealer_bj;
   result_t           res1, res2;

   card_generation #(.DECK(DECK)) u_cards (
      .clk   (clk),
      .reset (reset),
      .draw  (draw),
      .card  (card)
   );

   assign btn      = {next, stand, double, split, hit};
   assign btn_edge = btn & ~btn_reg;
   assign {next_e, stand_e, double_e, split_e, hit_e} = btn_edge;

   assign bet_in    = {1'b0, bet_8, bet_4, bet_2, bet_1};
   assign bet_dbl   = {bet_reg, 1'b0};
   assign double_ok = (p_cnt_reg == 4'd2) && (bet_dbl <= {1'b0, coin_reg});
   assign can_split = (state_reg == PLAYER) && double_ok && (card1_reg == p_card_reg);

   assign p_add      = add_card(p_hand_reg, card);
   assign s_add      = add_card(s_hand_reg, card);
   assign d_add      = add_card(d_hand_reg, card);
   assign split_base = '{aces: {3'b000, card1_reg == ACE}, score: card1_reg};
   assign h1_split   = add_card(split_base, card);

   assign player_bj = !split_reg && (p_cnt_reg == 4'd2) && (p_hand_reg.score == BLACKJACK);
   assign dealer_bj = (d_cnt_reg == 4'd2) && (d_hand_reg.score == BLACKJACK);
   assign res1      = hand_result(p_hand_reg.score, player_bj, d_hand_reg.score, dealer_bj);
   assign res2      = hand_result(s_hand_reg.score, 1'b0, d_hand_reg.score, dealer_bj);

   // Net delta of both hands, clamped to the 5-bit balance range.
   always_comb begin
      logic signed [7:0] bet_s, d1, d2, total;
      bet_s = $signed({3'b000, bet_reg});
      d1    = 8'sd0;
      d2    = 8'sd0;
      case (res1)
         RES_WIN:  d1 = bet_s + (player_bj ? $signed({4'b0000, bet_reg[4:1]}) : 8'sd0);
         RES_LOSE: d1 = -bet_s;
         default:  d1 = 8'sd0;
      endcase
      if (split_reg) begin
         case (res2)
            RES_WIN:  d2 = bet_s;
            RES_LOSE: d2 = -bet_s;
            default:  d2 = 8'sd0;
         endcase
      end
      total = $signed({3'b000, coin_reg}) + d1 + d2;
      if (total < 8'sd0) begin
         coin_settled = 5'd0;
      end else if (total > 8'sd31) begin
         coin_settled = 5'd31;
      end else begin
         coin_settled = total[4:0];
      end
   end

   always_comb begin
      state_next    = state_reg;
      bet_next      = bet_reg;
      coin_next     = coin_reg;
      p_hand_next   = p_hand_reg;
      s_hand_next   = s_hand_reg;
      d_hand_next   = d_hand_reg;
      p_card_next   = p_card_reg;
      s_card_next   = s_card_reg;
      card1_next    = card1_reg;
      p_cnt_next    = p_cnt_reg;
      d_cnt_next    = d_cnt_reg;
      deal_cnt_next = deal_cnt_reg;
      split_next    = split_reg;
      h1_bust_next  = h1_bust_reg;
      settled_next  = settled_reg;
      draw          = 1'b0;

      case (state_reg)
         BET: begin
            if (next_e && bet_in != 5'd0 && bet_in <= coin_reg) begin
               bet_next      = bet_in;
               deal_cnt_next = 2'd0;
               state_next    = DEAL_DEALER;
            end
         end
         DEAL_DEALER: begin
            if (deal_cnt_reg < 2'd2) begin
               draw          = 1'b1;
               d_hand_next   = d_add;
               d_cnt_next    = d_cnt_reg + 4'd1;
               deal_cnt_next = deal_cnt_reg + 2'd1;
            end else if (next_e) begin
               state_next = DEAL_PLAYER;
            end
         end
         DEAL_PLAYER: begin
            draw        = 1'b1;
            p_hand_next = p_add;
            p_card_next = card;
            p_cnt_next  = p_cnt_reg + 4'd1;
            if (p_cnt_reg == 4'd0) begin
               card1_next = card;
            end else begin
               state_next = PLAYER;
            end
         end
         PLAYER: begin
            if (player_bj) begin
               state_next = WAIT_DEALER;
            end else if (stand_e) begin
               state_next = DEALER;
            end else if (double_e && double_ok) begin
               draw        = 1'b1;
               bet_next    = bet_dbl[4:0];
               p_hand_next = p_add;
               p_card_next = card;
               p_cnt_next  = p_cnt_reg + 4'd1;
               state_next  = (p_add.score > BLACKJACK) ? RESULT : WAIT_DEALER;
            end else if (split_e && can_split) begin
               draw        = 1'b1;
               split_next  = 1'b1;
               s_hand_next = split_base;
               s_card_next = p_card_reg;
               p_hand_next = h1_split;
               p_card_next = card;
               state_next  = HAND1;
            end else if (hit_e) begin
               draw        = 1'b1;
               p_hand_next = p_add;
               p_card_next = card;
               p_cnt_next  = p_cnt_reg + 4'd1;
               if (p_add.score > BLACKJACK) begin
                  state_next = RESULT;
               end
            end
         end
         HAND1: begin
            // Leaving hand 1 deals hand 2 its second card on the same cycle.
            if ((next_e && h1_bust_reg) || (stand_e && !h1_bust_reg)) begin
               draw        = 1'b1;
               s_hand_next = s_add;
               s_card_next = card;
               state_next  = HAND2;
            end else if (hit_e && !h1_bust_reg) begin
               draw         = 1'b1;
               p_hand_next  = p_add;
               p_card_next  = card;
               h1_bust_next = (p_add.score > BLACKJACK);
            end
         end
         HAND2: begin
            if (stand_e) begin
               state_next = DEALER;
            end else if (hit_e) begin
               draw        = 1'b1;
               s_hand_next = s_add;
               s_card_next = card;
               if (s_add.score > BLACKJACK) begin
                  state_next = DEALER;
               end
            end
         end
         WAIT_DEALER: begin
            if (next_e) begin
               state_next = DEALER;
            end
         end
         DEALER: begin
            if (d_hand_reg.score < DEALER_STAND) begin
               draw        = 1'b1;
               d_hand_next = d_add;
               d_cnt_next  = d_cnt_reg + 4'd1;
            end else if (next_e) begin
               state_next = RESULT;
            end
         end
         RESULT: begin
            if (!settled_reg) begin
               coin_next    = coin_settled;
               settled_next = 1'b1;
            end
            if (next_e) begin
               bet_next      = 5'd0;
               p_hand_next   = '0;
               s_hand_next   = '0;
               d_hand_next   = '0;
               p_card_next   = '0;
               s_card_next   = '0;
               card1_next    = '0;
               p_cnt_next    = 4'd0;
               d_cnt_next    = 4'd0;
               deal_cnt_next = 2'd0;
               split_next    = 1'b0;
               h1_bust_next  = 1'b0;
               settled_next  = 1'b0;
               state_next    = BET;
            end
         end
         default: state_next = BET;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= BET;
         btn_reg      <= 5'd0;
         bet_reg      <= 5'd0;
         coin_reg     <= 5'(INIT_COIN);
         p_hand_reg   <= '0;
         s_hand_reg   <= '0;
         d_hand_reg   <= '0;
         p_card_reg   <= '0;
         s_card_reg   <= '0;
         card1_reg    <= '0;
         p_cnt_reg    <= 4'd0;
         d_cnt_reg    <= 4'd0;
         deal_cnt_reg <= 2'd0;
         split_reg    <= 1'b0;
         h1_bust_reg  <= 1'b0;
         settled_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         btn_reg      <= btn;
         bet_reg      <= bet_next;
         coin_reg     <= coin_next;
         p_hand_reg   <= p_hand_next;
         s_hand_reg   <= s_hand_next;
         d_hand_reg   <= d_hand_next;
         p_card_reg   <= p_card_next;
         s_card_reg   <= s_card_next;
         card1_reg    <= card1_next;
         p_cnt_reg    <= p_cnt_next;
         d_cnt_reg    <= d_cnt_next;
         deal_cnt_reg <= deal_cnt_next;
         split_reg    <= split_next;
         h1_bust_reg  <= h1_bust_next;
         settled_reg  <= settled_next;
      end
   end

   assign player_current_score       = p_hand_reg.score;
   assign player_new_card            = p_card_reg;
   assign player_current_score_split = s_hand_reg.score;
   assign player_new_card_split      = s_card_reg;
   assign dealer_current_score       = d_hand_reg.score;
   assign current_coin               = coin_reg;
   assign Win  = (state_reg == RESULT) && (res1 == RES_WIN);
   assign Lose = (state_reg == RESULT) && (res1 == RES_LOSE);
   assign Draw = (state_reg == RESULT) && (res1 == RES_DRAW);

endmodule

// File: tb/tb_blackjack_top.sv
// Directed rounds on four tables sharing the buttons, each table loaded with its own deck;
// expectations are queued with each step and compared once the table has settled.
module tb_blackjack_top;

   localparam logic [95:0] D0 = {6'd7, 6'd10, 6'd10, 6'd8, 6'd4, 6'd10, 6'd2, 6'd9,
                                 6'd5, 6'd3, 6'd6, 6'd11, 6'd10, 6'd10, 6'd8, 6'd2};
   localparam logic [95:0] D1 = {6'd7, 6'd10, 6'd10, 6'd8, 6'd2, 6'd9, 6'd5, 6'd3,
                                 6'd6, 6'd11, 6'd10, 6'd10, 6'd8, 6'd2, 6'd4, 6'd10};
   localparam logic [95:0] D2 = {6'd7, 6'd10, 6'd10, 6'd11, 6'd4, 6'd10, 6'd2, 6'd9,
                                 6'd5, 6'd3, 6'd6, 6'd11, 6'd10, 6'd10, 6'd8, 6'd2};
   localparam logic [95:0] D3 = {6'd7, 6'd10, 6'd10, 6'd10, 6'd8, 6'd4, 6'd8, 6'd2,
                                 6'd9, 6'd5, 6'd3, 6'd6, 6'd11, 6'd10, 6'd10, 6'd8};

   localparam int B_HIT = 0, B_SPLIT = 1, B_DOUBLE = 2, B_STAND = 3, B_NEXT = 4;

   typedef enum int {S_PSCORE, S_PCARD, S_SSCORE, S_SCARD, S_DSCORE, S_COIN,
                     S_CANSPLIT, S_WIN, S_LOSE, S_DRAW} sig_e;

   typedef struct {
      string tag;
      int    inst;
      sig_e  sig;
      int    exp;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] btns = 5'd0;
   logic [3:0] bet = 4'd0;

   logic [5:0] pcs [4];
   logic [5:0] pnc [4];
   logic [5:0] pcss[4];
   logic [5:0] pncs[4];
   logic [5:0] dcs [4];
   logic [4:0] coin[4];
   logic       cs  [4];
   logic       win [4];
   logic       lose[4];
   logic       drw [4];

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_dut
         blackjack_top #(
            .DECK      (gi == 0 ? D0 : gi == 1 ? D1 : gi == 2 ? D2 : D3),
            .INIT_COIN (10)
         ) dut (
            .clk                        (clk),
            .reset                      (reset),
            .next                       (btns[B_NEXT]),
            .hit                        (btns[B_HIT]),
            .stand                      (btns[B_STAND]),
            .double                     (btns[B_DOUBLE]),
            .split                      (btns[B_SPLIT]),
            .bet_8                      (bet[3]),
            .bet_4                      (bet[2]),
            .bet_2                      (bet[1]),
            .bet_1                      (bet[0]),
            .player_current_score       (pcs[gi]),
            .player_new_card            (pnc[gi]),
            .player_current_score_split (pcss[gi]),
            .player_new_card_split      (pncs[gi]),
            .dealer_current_score       (dcs[gi]),
            .current_coin               (coin[gi]),
            .can_split                  (cs[gi]),
            .Win                        (win[gi]),
            .Lose                       (lose[gi]),
            .Draw                       (drw[gi])
         );
      end
   endgenerate

   function automatic int observe(input int inst, input sig_e sig);
      case (sig)
         S_PSCORE:   return int'(pcs[inst]);
         S_PCARD:    return int'(pnc[inst]);
         S_SSCORE:   return int'(pcss[inst]);
         S_SCARD:    return int'(pncs[inst]);
         S_DSCORE:   return int'(dcs[inst]);
         S_COIN:     return int'(coin[inst]);
         S_CANSPLIT: return int'(cs[inst]);
         S_WIN:      return int'(win[inst]);
         S_LOSE:     return int'(lose[inst]);
         default:    return int'(drw[inst]);
      endcase
   endfunction

   task automatic expect_val(input string tag, input int inst, input sig_e sig, input int exp);
      exp_t e;
      e.tag  = tag;
      e.inst = inst;
      e.sig  = sig;
      e.exp  = exp;
      sb.push_back(e);
   endtask

   task automatic check_all();
      exp_t e;
      int   obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.inst, e.sig);
         checks++;
         assert (obs === e.exp) begin
            $display("check %s table%0d = %0d ok", e.tag, e.inst, obs);
         end else begin
            errors++;
            $error("FAIL %s table%0d: observed %0d expected %0d", e.tag, e.inst, obs, e.exp);
         end
      end
   endtask

   task automatic press(input int b);
      btns[b] = 1'b1;
      repeat (2) @(negedge clk);
      btns[b] = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      do_reset();
      expect_val("reset_coin", 0, S_COIN, 10);
      expect_val("reset_pscore", 0, S_PSCORE, 0);
      expect_val("reset_dscore", 0, S_DSCORE, 0);
      expect_val("reset_cansplit", 0, S_CANSPLIT, 0);
      expect_val("reset_lose", 0, S_LOSE, 0);
      check_all();

      // Default deck: hit busts the player.
      bet = 4'd3;
      press(B_NEXT);
      press(B_NEXT);
      expect_val("a_dscore", 0, S_DSCORE, 17);
      expect_val("a_pscore", 0, S_PSCORE, 18);
      expect_val("a_pcard", 0, S_PCARD, 8);
      expect_val("a_cansplit", 0, S_CANSPLIT, 0);
      check_all();
      press(B_HIT);
      expect_val("a_hitcard", 0, S_PCARD, 4);
      expect_val("a_bust", 0, S_PSCORE, 22);
      expect_val("a_lose", 0, S_LOSE, 1);
      expect_val("a_win", 0, S_WIN, 0);
      expect_val("a_coin", 0, S_COIN, 7);
      check_all();
      press(B_NEXT);
      expect_val("a_clr_pscore", 0, S_PSCORE, 0);
      expect_val("a_clr_dscore", 0, S_DSCORE, 0);
      expect_val("a_clr_lose", 0, S_LOSE, 0);
      expect_val("a_keep_coin", 0, S_COIN, 7);
      check_all();
      bet = 4'd8;
      press(B_NEXT);
      expect_val("a_overbet_ignored", 0, S_DSCORE, 0);
      check_all();

      // Double down to 20 against dealer 17.
      do_reset();
      bet = 4'd3;
      press(B_NEXT);
      press(B_NEXT);
      expect_val("b_pscore", 1, S_PSCORE, 18);
      check_all();
      press(B_DOUBLE);
      expect_val("b_dblcard", 1, S_PCARD, 2);
      expect_val("b_dblscore", 1, S_PSCORE, 20);
      check_all();
      press(B_NEXT);
      expect_val("b_win_early", 1, S_WIN, 0);
      check_all();
      press(B_NEXT);
      expect_val("b_dscore", 1, S_DSCORE, 17);
      expect_val("b_win", 1, S_WIN, 1);
      expect_val("b_draw", 1, S_DRAW, 0);
      expect_val("b_coin", 1, S_COIN, 16);
      check_all();

      // Natural blackjack; a late hit must be ignored.
      do_reset();
      bet = 4'd3;
      press(B_NEXT);
      press(B_NEXT);
      expect_val("c_bj_score", 2, S_PSCORE, 21);
      check_all();
      press(B_HIT);
      expect_val("c_hit_ignored", 2, S_PSCORE, 21);
      check_all();
      press(B_NEXT);
      press(B_NEXT);
      expect_val("c_win", 2, S_WIN, 1);
      expect_val("c_lose", 2, S_LOSE, 0);
      expect_val("c_coin", 2, S_COIN, 14);
      check_all();

      // Split tens: hand 1 busts, hand 2 wins.
      do_reset();
      bet = 4'd3;
      press(B_NEXT);
      press(B_NEXT);
      expect_val("d_cansplit", 3, S_CANSPLIT, 1);
      expect_val("d_pscore", 3, S_PSCORE, 20);
      check_all();
      press(B_SPLIT);
      expect_val("d_h1_score", 3, S_PSCORE, 18);
      expect_val("d_h1_card", 3, S_PCARD, 8);
      expect_val("d_h2_score", 3, S_SSCORE, 10);
      expect_val("d_h2_card", 3, S_SCARD, 10);
      expect_val("d_cansplit_off", 3, S_CANSPLIT, 0);
      check_all();
      press(B_HIT);
      expect_val("d_h1_bust", 3, S_PSCORE, 22);
      check_all();
      press(B_NEXT);
      expect_val("d_h2_deal", 3, S_SSCORE, 18);
      expect_val("d_h2_dealcard", 3, S_SCARD, 8);
      check_all();
      press(B_HIT);
      expect_val("d_h2_hit", 3, S_SSCORE, 20);
      check_all();
      press(B_STAND);
      press(B_NEXT);
      expect_val("d_lose", 3, S_LOSE, 1);
      expect_val("d_win", 3, S_WIN, 0);
      expect_val("d_coin", 3, S_COIN, 10);
      check_all();

      // Reset mid-round, then a zero bet must not start a round.
      do_reset();
      bet = 4'd3;
      press(B_NEXT);
      press(B_NEXT);
      expect_val("e_pre_pscore", 0, S_PSCORE, 18);
      check_all();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      expect_val("e_rst_coin", 0, S_COIN, 10);
      expect_val("e_rst_pscore", 0, S_PSCORE, 0);
      expect_val("e_rst_pcard", 0, S_PCARD, 0);
      expect_val("e_rst_dscore", 0, S_DSCORE, 0);
      check_all();
      bet = 4'd0;
      repeat (2) @(negedge clk);
      press(B_NEXT);
      press(B_NEXT);
      expect_val("e_zero_bet_dscore", 0, S_DSCORE, 0);
      expect_val("e_zero_bet_pscore", 0, S_PSCORE, 0);
      check_all();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
